// File: rtl/udc_counter.sv
// Parametrised up/down counter: programmable limit, wrap/saturate, synchronous load,
// enable-gated prescaler and a registered one-cycle terminal-count pulse.
module udc_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             udc_clk,
  input  logic             udc_rst,
  input  logic             udc_en,
  input  logic             udc_sel,
  input  logic             udc_mode,
  input  logic             udc_ld,
  input  logic [WIDTH-1:0] udc_d,
  input  logic [WIDTH-1:0] udc_max,
  output logic [WIDTH-1:0] udc_q,
  output logic             udc_tc
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    pre;
  logic             step_c;
  logic [WIDTH-1:0] q_step_c;
  logic             tc_step_c;
  logic [WIDTH-1:0] q_load_c;

  assign step_c   = udc_en && (pre == PRE_LAST);
  assign q_load_c = (udc_d > udc_max) ? udc_max : udc_d;

  // Next count and terminal flag for a step, from direction, limit and mode.
  always_comb begin
    q_step_c  = udc_q;
    tc_step_c = 1'b0;
    if (udc_sel) begin
      if (udc_q < udc_max) begin
        q_step_c = udc_q + WIDTH'(1);
      end else begin
        q_step_c  = udc_mode ? udc_max : '0;
        tc_step_c = 1'b1;
      end
    end else begin
      if (udc_q > udc_max) begin
        // Limit was lowered below the count: snap to it without a terminal event.
        q_step_c = udc_max;
      end else if (udc_q != '0) begin
        q_step_c = udc_q - WIDTH'(1);
      end else begin
        q_step_c  = udc_mode ? '0 : udc_max;
        tc_step_c = 1'b1;
      end
    end
  end

  // Prescaler: advances only while enabled, cleared by load.
  always_ff @(posedge udc_clk or negedge udc_rst) begin
    if (!udc_rst) begin
      pre <= '0;
    end else if (udc_ld) begin
      pre <= '0;
    end else if (udc_en) begin
      pre <= step_c ? '0 : pre + PW'(1);
    end
  end

  // Count and terminal-count registers; load outranks step.
  always_ff @(posedge udc_clk or negedge udc_rst) begin
    if (!udc_rst) begin
      udc_q  <= '0;
      udc_tc <= 1'b0;
    end else if (udc_ld) begin
      udc_q  <= q_load_c;
      udc_tc <= 1'b0;
    end else if (step_c) begin
      udc_q  <= q_step_c;
      udc_tc <= tc_step_c;
    end else begin
      udc_tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_udc_counter.sv
// Bench for udc_counter: directed tables/sequences plus randomized cycles against a
// behavioural model, on two instances (PRESCALE=1 and PRESCALE=3).
module tb_udc_counter;

  typedef struct packed {
    logic       en;
    logic       sel;
    logic       mode;
    logic       ld;
    logic [3:0] d;
    logic [3:0] max;
  } in_t;

  typedef struct {
    logic       en;
    logic       sel;
    logic       mode;
    logic       ld;
    logic [3:0] d;
    logic [3:0] max;
    int         q;
    int         tc;
  } vec_t;

  logic       clk;
  logic       rst_a, rst_b;
  in_t        ia, ib;
  logic [3:0] qa, qb;
  logic       tca, tcb;

  int checks = 0;
  int errors = 0;
  int mq[2], mpre[2], mtc[2];

  udc_counter #(.WIDTH(4), .PRESCALE(1)) dut_a (
    .udc_clk(clk), .udc_rst(rst_a), .udc_en(ia.en), .udc_sel(ia.sel),
    .udc_mode(ia.mode), .udc_ld(ia.ld), .udc_d(ia.d), .udc_max(ia.max),
    .udc_q(qa), .udc_tc(tca)
  );

  udc_counter #(.WIDTH(4), .PRESCALE(3)) dut_b (
    .udc_clk(clk), .udc_rst(rst_b), .udc_en(ib.en), .udc_sel(ib.sel),
    .udc_mode(ib.mode), .udc_ld(ib.ld), .udc_d(ib.d), .udc_max(ib.max),
    .udc_q(qb), .udc_tc(tcb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: count kept as an integer, prescaler as a count of enabled cycles.
  task automatic model(input int k, input int presc, input in_t s);
    int mx;
    mx = int'(s.max);
    if (s.ld) begin
      mq[k] = (int'(s.d) > mx) ? mx : int'(s.d);
      mpre[k] = 0;
      mtc[k] = 0;
    end else if (s.en && mpre[k] + 1 == presc) begin
      mpre[k] = 0;
      mtc[k] = 0;
      if (s.sel) begin
        if (mq[k] < mx) mq[k] = mq[k] + 1;
        else begin
          mq[k] = s.mode ? mx : 0;
          mtc[k] = 1;
        end
      end else begin
        if (mq[k] > mx) mq[k] = mx;
        else if (mq[k] > 0) mq[k] = mq[k] - 1;
        else begin
          mq[k] = s.mode ? 0 : mx;
          mtc[k] = 1;
        end
      end
    end else begin
      if (s.en) mpre[k] = mpre[k] + 1;
      mtc[k] = 0;
    end
  endtask

  task automatic model_reset(input int k);
    mq[k] = 0;
    mpre[k] = 0;
    mtc[k] = 0;
  endtask

  // One clock: update model on the edge, compare both instances just after it.
  task automatic tick();
    @(posedge clk);
    if (rst_a) model(0, 1, ia); else model_reset(0);
    if (rst_b) model(1, 3, ib); else model_reset(1);
    #1;
    chk("model_q_a", int'(qa), mq[0]);
    chk("model_tc_a", int'(tca), mtc[0]);
    chk("model_q_b", int'(qb), mq[1]);
    chk("model_tc_b", int'(tcb), mtc[1]);
  endtask

  function automatic in_t mk(input logic en, input logic sel, input logic mode,
                             input logic ld, input logic [3:0] d, input logic [3:0] max);
    in_t r;
    r.en = en; r.sel = sel; r.mode = mode; r.ld = ld; r.d = d; r.max = max;
    return r;
  endfunction

  vec_t tbl[21];
  int   pre_q[8];
  int   en_pat[8];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd3,  4'd5,  3,  0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd5,  4,  0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd5,  5,  0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd5,  5,  1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd5,  5,  1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd5,  5,  1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd5,  5,  1};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  4'd5,  4,  0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  4'd5,  3,  0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd12, 4'd9,  9,  0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  4'd9,  0,  1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd3,  4'd9,  3,  0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd2,  2,  0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0,  0,  1};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0,  0,  1};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  0,  1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  0,  0};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd15, 15, 1};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  4'd15, 0,  1};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd14, 4'd15, 14, 0};
    tbl[20] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd8,  8,  1};
    en_pat = '{1, 1, 0, 0, 1, 1, 1, 1};
    pre_q  = '{0, 0, 0, 0, 1, 1, 1, 2};

    rst_a = 1'b0;
    rst_b = 1'b0;
    ia = '0;
    ib = '0;
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q_a", int'(qa), 0);
    chk("reset_tc_a", int'(tca), 0);
    chk("reset_q_b", int'(qb), 0);
    chk("reset_tc_b", int'(tcb), 0);
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Full-range wrap up: 1..15, 0, 1 with tc only on the wrap.
    ia = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd15);
    for (int i = 0; i < 17; i++) begin
      tick();
      chk("wrap_up_q", int'(qa), (i + 1) % 16);
      chk("wrap_up_tc", int'(tca), (i == 15) ? 1 : 0);
    end

    // Modulus-10 down count from 0: 9..0, 9.
    ia = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd9);
    tick();
    chk("down_load_q", int'(qa), 0);
    ia = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd9);
    for (int i = 0; i < 11; i++) begin
      tick();
      chk("down_q", int'(qa), (i == 10) ? 9 : 9 - i);
      chk("down_tc", int'(tca), (i == 0 || i == 10) ? 1 : 0);
    end

    for (int i = 0; i < 21; i++) begin
      ia = mk(tbl[i].en, tbl[i].sel, tbl[i].mode, tbl[i].ld, tbl[i].d, tbl[i].max);
      tick();
      chk($sformatf("tbl%0d_q", i), int'(qa), tbl[i].q);
      chk($sformatf("tbl%0d_tc", i), int'(tca), tbl[i].tc);
    end
    ia = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd15);

    // Prescaler: steps only on every 3rd enabled cycle; disabled cycles freeze it.
    for (int i = 0; i < 8; i++) begin
      ib = mk(en_pat[i] != 0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd15);
      tick();
      chk("pre_q", int'(qb), pre_q[i]);
      chk("pre_tc", int'(tcb), 0);
    end
    // Load on what would be a step cycle clears the prescaler.
    ib = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd15);
    repeat (2) tick();
    ib = mk(1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 4'd15);
    tick();
    chk("pre_ld_q", int'(qb), 5);
    ib = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd15);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pre_after_ld_q", int'(qb), (i == 2) ? 6 : 5);
    end

    // Async reset between edges with A at 7.
    ia = mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd6, 4'd15);
    tick();
    ia = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd15);
    tick();
    chk("pre_rst_q_a", int'(qa), 7);
    #3;
    rst_a = 1'b0;
    rst_b = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    chk("async_q_a", int'(qa), 0);
    chk("async_tc_a", int'(tca), 0);
    chk("async_q_b", int'(qb), 0);
    #2;
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_q_a", int'(qa), i + 1);
      chk("post_rst_q_b", int'(qb), (i == 2) ? 1 : 0);
    end

    // Randomized traffic on both instances against the model.
    for (int i = 0; i < 600; i++) begin
      ia.en   = ($urandom_range(0, 3) != 0);
      ia.sel  = 1'($urandom);
      ia.mode = 1'($urandom);
      ia.ld   = ($urandom_range(0, 15) == 0);
      ia.d    = 4'($urandom);
      if ($urandom_range(0, 7) == 0)
        ia.max = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom);
      ib.en   = ($urandom_range(0, 3) != 0);
      ib.sel  = 1'($urandom);
      ib.mode = 1'($urandom);
      ib.ld   = ($urandom_range(0, 15) == 0);
      ib.d    = 4'($urandom);
      if ($urandom_range(0, 7) == 0)
        ib.max = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
